imem_responder: RTL

Responder end of the instruction-fetch interface: serves fetch requests against a 1 KiB instruction store mapped at 0x3000.
- Request and response channels use valid/ready handshakes.
- Read latency is configurable through wait states.
- Faulting addresses return an error response.
- A load port lets a test harness or boot loader write program words into the store.

---
 rtl/imem_responder_pkg.sv | 15 +
 rtl/imem_array.sv | 28 ++
 rtl/imem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imem_responder_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
package imem_responder_pkg;

  localparam logic [31:0] IM_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam int unsigned IM_WORDS     = 256;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } im_state_e;

endpackage

// File: rtl/imem_array.sv
// Word-wide instruction store: synchronous write, combinational read.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-3:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [ADDR_WIDTH-3:0] rd_addr,
  output logic [31:0]           rd_data
);

  localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem [WORDS];

  // Write port; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: valid/ready request/response with wait states,
// address fault detection and a load port into the backing store.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = IM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-3:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  // One past the last valid byte, kept in 33 bits so the top of the map cannot wrap
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + (33'd1 << ADDR_WIDTH);

  im_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;

  logic             accept;
  logic             enter_resp;
  logic             rsp_done;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_err;
  logic [31:0]      mem_word;
  logic [31:0]      rd_word;

  // Address decode of the live request
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr < BASE_ADDR) ||
                   ({1'b0, req_addr} >= LIMIT);
  assign req_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);

  // With zero wait states RESP is entered on the accept edge, before the latch is valid
  assign sel_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign sel_err = (state_q == IDLE) ? req_err : err_q;

  imem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (sel_idx),
    .rd_data (mem_word)
  );

  // A load landing on the RESP-entry edge must be visible in the response
  assign rd_word = (ld_en && (ld_addr == sel_idx)) ? ld_data : mem_word;

  // Next-state, counter and handshake decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !ld_en;
        if (req_valid && !ld_en) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= NOP_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= req_idx;
        err_q <= req_err;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= sel_err;
        rsp_data  <= sel_err ? NOP_WORD : rd_word;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
